seven_seg_scan_scheduler: RTL
=============================

// Module: seven_seg_scan_scheduler
// PURPOSE
//  Time-multiplexing controller for the dynamic seven-segment display. It holds a
//  character buffer of abcdefgh patterns and scans it one digit at a time, with a
//  blanking gap between digits to suppress ghosting. Sits between lab logic (writer)
//  and the board abcdefgh/digit pins. Buffer updates are double-buffered: they become
//  visible only at a frame boundary.
// PARAMETERS
//  w_digit      8   number of physical digits (one-hot digit select width)
//  depth        16  message buffer entries (power of 2, >= w_digit)
//  scan_cycles  50000  clk cycles per digit slot, including blank (1 ms at 50 MHz)
//  blank_cycles 500 cycles of each slot with all digits off; must be < scan_cycles
//  scroll_frames 250 frames per scroll step (used only with SEVEN_SEG_SCROLL_EN)
// PORTS
//  clk       in  1                  system clock
//  rst_n     in  1                  asynchronous, active-low reset
//  enable    in  1                  1 = scan; 0 = go idle at end of current slot
//  wr_valid  in  1                  shadow-buffer write request
//  wr_ready  out 1                  always 1 after reset (shadow write takes 1 cycle)
//  wr_addr   in  $clog2(depth)      shadow entry index
//  wr_char   in  8                  abcdefgh pattern (h = dot), 1 = segment lit
//  msg_len   in  $clog2(depth)+1    message length, sampled at commit; 0 = all blank
//  commit    in  1                  pulse: copy shadow -> active at next frame boundary
//  pending   out 1                  commit requested, copy not yet done
//  abcdefgh  out 8                  segment pattern of the selected digit
//  digit     out w_digit            one-hot digit enable, active-high
//  frame_tick out 1                 1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset: state IDLE; abcdefgh=0, digit=0, wr_ready=0 for first cycle then 1, pending=0,
//   frame_tick=0, active and shadow buffers all 8'h00, active_len=0, offset=0.
//  All outputs registered. FSM:
//   IDLE  : digit=0. enable=1 -> SHOW with pos=0, slot counter=0.
//   SHOW  : digit/abcdefgh driven for scan_cycles-blank_cycles cycles -> BLANK.
//   BLANK : digit=0, abcdefgh=0 for blank_cycles cycles. Then if pos==w_digit-1:
//           frame end (frame_tick=1, pos=0, apply pending commit). Next state:
//           enable ? SHOW : IDLE. enable is checked only here; no slot is ever truncated.
//  Position p (0 = leftmost) drives digit[w_digit-1-p].
//  Char index i = (offset + p) mod active_len; abcdefgh = active[i] when p < active_len
//   or scrolling is active, else 8'h00. active_len=0 -> always 8'h00.
//  Commit: pending set on commit pulse; at frame end the shadow is copied to active,
//   active_len <= latched msg_len (clamped to depth), offset <= 0, pending <= 0.
//   A second commit while pending is merged (one copy, latest msg_len wins).
//   A commit in the same cycle as the frame end takes effect at the *following* frame end.
//   Commit in IDLE is applied immediately on the next cycle.
//  Shadow write and commit in the same cycle: the write is included in the copy.
//  Reset mid-frame: immediate return to reset values; the display goes dark.
// CONFIGURATION
//  SEVEN_SEG_SCROLL_EN defined: if active_len > w_digit, offset increments every
//   scroll_frames frames (counted on frame_tick) and wraps at active_len-1 -> 0.
//   offset is held at 0 when active_len <= w_digit.
//  Undefined: offset is fixed at 0, the first w_digit chars are shown, and there is no
//   frame counter logic.
// STRUCTURE
//  seven_seg_pkg: seven_seg_encoding_e (F,P,G,A,E,space ...), SEG_BLANK = 8'h00,
//   scan_state_e {IDLE, SHOW, BLANK}.
//  Sub-module seven_seg_slot_timer: slot counter producing show_done/blank_done strobes.
// TESTING  (w_digit=4, depth=8, scan_cycles=4, blank_cycles=1, scroll_frames=2)
//  1. Reset release, enable=0 -> digit=0, abcdefgh=0, pending=0, wr_ready=1 after 1 cycle.
//  2. Write F,P,G,A to addr 0-3, msg_len=4, commit, enable=1 -> frame shows
//     digit 1000/F, 0100/P, 0010/G, 0001/A; each slot 3 cycles lit + 1 dark;
//     frame_tick every 16 cycles.
//  3. Mid-frame: write E at addr0 and commit -> current frame is unchanged, pending=1;
//     the next frame shows E first and pending=0 after the boundary.
//  4. enable dropped during slot 1 -> slot completes, then IDLE with digit=0;
//     no partial slot occurs.
//  5. SCROLL_EN, msg_len=6 -> after 2 frames the window is chars 1-4; after 12 frames
//     the offset wraps to 0. Without the macro the window stays at 0-3.
//  6. rst_n asserted mid-SHOW -> outputs 0 asynchronously; buffers are cleared.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment scan scheduler: segment encodings and scan states.
// Segment byte layout is abcdefgh with a in bit 7 and the dot (h) in bit 0.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [7:0] {
        SEG_SPACE = 8'h00,
        SEG_DOT   = 8'h01,
        SEG_0     = 8'hFC,
        SEG_1     = 8'h60,
        SEG_A     = 8'hEE,
        SEG_E     = 8'h9E,
        SEG_F     = 8'h8E,
        SEG_G     = 8'hBC,
        SEG_P     = 8'hCE
    } seven_seg_encoding_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Per-slot down-counter: loaded on entry to SHOW or BLANK, strobes when the phase
// reaches terminal count so the scheduler can advance.
module seven_seg_slot_timer #(
    parameter int scan_cycles  = 50000,
    parameter int blank_cycles = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_show,
    input  logic start_blank,
    input  logic in_show,
    input  logic in_blank,
    output logic show_done,
    output logic blank_done
);

    localparam int CW = $clog2(scan_cycles);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(scan_cycles - blank_cycles - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(blank_cycles - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start_show) begin
            count <= SHOW_LOAD;
        end else if (start_blank) begin
            count <= BLANK_LOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign show_done  = in_show  && (count == '0);
    assign blank_done = in_blank && (count == '0);

endmodule

// File: rtl/seven_seg_scan_scheduler.sv
// Time-multiplexed seven-segment scanner with blanking gaps and a double-buffered message.
// Optional SEVEN_SEG_SCROLL_EN: scrolls messages longer than the display every scroll_frames.
module seven_seg_scan_scheduler
    import seven_seg_pkg::*;
#(
    parameter int w_digit       = 8,
    parameter int depth         = 16,
    parameter int scan_cycles   = 50000,
    parameter int blank_cycles  = 500,
    parameter int scroll_frames = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(depth)-1:0]   wr_addr,
    input  logic [7:0]                 wr_char,
    input  logic [$clog2(depth):0]     msg_len,
    input  logic                       commit,
    output logic                       pending,
    output logic [7:0]                 abcdefgh,
    output logic [w_digit-1:0]         digit,
    output logic                       frame_tick
);

    localparam int AW = $clog2(depth);
    localparam int LW = AW + 1;
    localparam int PW = (w_digit > 1) ? $clog2(w_digit) : 1;

    scan_state_e    state;
    logic [PW-1:0]  pos;
    logic [7:0]     shadow [depth];
    logic [7:0]     active [depth];
    logic [LW-1:0]  active_len;
    logic [LW-1:0]  pend_len;

    logic           show_done;
    logic           blank_done;
    logic           last_pos;
    logic           frame_end;
    logic           apply_now;
    logic           go_show;
    logic [LW-1:0]  len_clamped;
    logic [LW-1:0]  next_len;
    logic [PW-1:0]  next_pos;
    logic [LW-1:0]  next_off;
    logic [LW-1:0]  idx;
    logic [7:0]     seg_next;
    logic [w_digit-1:0] digit_next;

`ifdef SEVEN_SEG_SCROLL_EN
    localparam int FW = (scroll_frames > 1) ? $clog2(scroll_frames) : 1;
    localparam logic [FW-1:0] FRAME_LOAD = FW'(scroll_frames - 1);

    logic [LW-1:0]  offset;
    logic [FW-1:0]  frame_cnt;
    logic           scrolling;
    logic           scroll_step;

    assign scrolling   = active_len > LW'(w_digit);
    assign scroll_step = frame_end && scrolling && (frame_cnt == '0);
`endif

    seven_seg_slot_timer #(
        .scan_cycles  (scan_cycles),
        .blank_cycles (blank_cycles)
    ) u_slot_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_show  (go_show),
        .start_blank (show_done),
        .in_show     (state == SHOW),
        .in_blank    (state == BLANK),
        .show_done   (show_done),
        .blank_done  (blank_done)
    );

    // The slot being entered must already see a commit applied on the same edge,
    // so the lookup reads the shadow copy whenever the copy is happening now.
    always_comb begin
        last_pos    = (pos == PW'(w_digit - 1));
        frame_end   = (state == BLANK) && blank_done && last_pos;
        apply_now   = pending && !commit && ((state == IDLE) || frame_end);
        go_show     = ((state == IDLE) && enable && !pending && !commit) ||
                      ((state == BLANK) && blank_done && enable);
        len_clamped = (pend_len > LW'(depth)) ? LW'(depth) : pend_len;
        next_len    = apply_now ? len_clamped : active_len;
        next_pos    = ((state == BLANK) && !last_pos) ? pos + PW'(1) : '0;

`ifdef SEVEN_SEG_SCROLL_EN
        if (apply_now) begin
            next_off = '0;
        end else if (scroll_step) begin
            next_off = (offset == active_len - LW'(1)) ? '0 : offset + LW'(1);
        end else begin
            next_off = offset;
        end
`else
        next_off = '0;
`endif

        idx = next_off + LW'(next_pos);
        if (idx >= next_len) begin
            idx = idx - next_len;
        end

        seg_next = SEG_BLANK;
        if (LW'(next_pos) < next_len) begin
            seg_next = apply_now ? shadow[idx[AW-1:0]] : active[idx[AW-1:0]];
        end

        digit_next = '0;
        for (int i = 0; i < w_digit; i++) begin
            digit_next[i] = (PW'(w_digit - 1 - i) == next_pos);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pos        <= '0;
            digit      <= '0;
            abcdefgh   <= SEG_BLANK;
            frame_tick <= 1'b0;
            wr_ready   <= 1'b0;
            pending    <= 1'b0;
            pend_len   <= '0;
            active_len <= '0;
            for (int i = 0; i < depth; i++) begin
                shadow[i] <= SEG_BLANK;
                active[i] <= SEG_BLANK;
            end
`ifdef SEVEN_SEG_SCROLL_EN
            offset    <= '0;
            frame_cnt <= FRAME_LOAD;
`endif
        end else begin
            wr_ready   <= 1'b1;
            frame_tick <= frame_end;

            if (wr_valid && wr_ready) begin
                shadow[wr_addr] <= wr_char;
            end

            // A commit landing on the frame-end edge is deferred to the next frame end.
            if (commit) begin
                pending  <= 1'b1;
                pend_len <= msg_len;
            end else if (apply_now) begin
                pending    <= 1'b0;
                active_len <= len_clamped;
                for (int i = 0; i < depth; i++) begin
                    active[i] <= shadow[i];
                end
            end

`ifdef SEVEN_SEG_SCROLL_EN
            offset <= next_off;
            if (apply_now || !scrolling) begin
                frame_cnt <= FRAME_LOAD;
            end else if (frame_end) begin
                frame_cnt <= (frame_cnt == '0) ? FRAME_LOAD : frame_cnt - FW'(1);
            end
`endif

            case (state)
                IDLE: begin
                    if (go_show) begin
                        state    <= SHOW;
                        pos      <= next_pos;
                        digit    <= digit_next;
                        abcdefgh <= seg_next;
                    end else begin
                        digit    <= '0;
                        abcdefgh <= SEG_BLANK;
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        state    <= BLANK;
                        digit    <= '0;
                        abcdefgh <= SEG_BLANK;
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        pos <= next_pos;
                        if (enable) begin
                            state    <= SHOW;
                            digit    <= digit_next;
                            abcdefgh <= seg_next;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    digit    <= '0;
                    abcdefgh <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule
